// File: rtl/alu_control_pipe.sv
// rtl/alu_control_pipe.sv - registered ALU control decode with multiply/divide busy tracking
module alu_control_pipe #(
    parameter int CTRL_W     = 4,
    parameter int MD_LATENCY = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [5:0]        Opcode,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Function,
    input  logic              stall_in,
    input  logic              flush,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              JRControl,
    output logic              illegal,
    output logic              md_start,
    output logic              md_busy
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]  alu_ctrl_q, alu_ctrl_d;
    logic               jr_q, jr_d;
    logic               illegal_q, illegal_d;
    logic               md_start_q, md_start_d;

    logic [3:0]         dec_code;
    logic               dec_jr;
    logic               dec_ill;
    logic               dec_md;
    logic               accept;

    always_comb begin
        dec_code = 4'b0000;
        dec_jr   = 1'b0;
        dec_ill  = 1'b0;
        case (ALUOp)
            2'b00: begin
                case (Function)
                    6'b100000: dec_code = 4'b0000;
                    6'b100010: dec_code = 4'b0001;
                    6'b100100: dec_code = 4'b0010;
                    6'b100101: dec_code = 4'b0011;
                    6'b000000: dec_code = 4'b0100;
                    6'b000010: dec_code = 4'b0101;
                    6'b000011: dec_code = 4'b0110;
                    6'b100111: dec_code = 4'b0111;
                    6'b101010: dec_code = 4'b1000;
                    6'b011000: dec_code = 4'b1001;
                    6'b011001: dec_code = 4'b1010;
                    6'b011010: dec_code = 4'b1011;
                    6'b011011: dec_code = 4'b1100;
                    6'b001000: dec_jr   = 1'b1;
                    default:   dec_ill  = 1'b1;
                endcase
            end
            2'b01: dec_code = 4'b0001;
            2'b10: dec_code = 4'b0000;
            default: begin
                case (Opcode)
                    6'b001100: dec_code = 4'b0010;
                    6'b000100: dec_code = 4'b0001;
                    6'b000101: dec_code = 4'b0001;
                    6'b001101: dec_code = 4'b0011;
                    6'b001010: dec_code = 4'b1000;
                    default:   dec_code = 4'b0000;
                endcase
            end
        endcase
    end

    // Only R-type mult/multu/div/divu produce codes 1001..1100.
    assign dec_md   = (ALUOp == 2'b00) && (dec_code >= 4'd9) && (dec_code <= 4'd12);

    assign md_busy  = (state_q == S_BUSY);
    assign in_ready = !stall_in && !md_busy && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        jr_d        = jr_q;
        illegal_d   = illegal_q;
        md_start_d  = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
            cnt_d       = '0;
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
                alu_ctrl_d  = CTRL_W'(dec_code);
                jr_d        = dec_jr;
                illegal_d   = dec_ill;
            end else if (!stall_in) begin
                out_valid_d = 1'b0;
            end

            // Busy countdown runs independently of stall_in.
            case (state_q)
                S_IDLE: begin
                    if (accept && dec_md) begin
                        state_d    = S_BUSY;
                        cnt_d      = CNT_W'(MD_LATENCY - 1);
                        md_start_d = 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            jr_q        <= 1'b0;
            illegal_q   <= 1'b0;
            md_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            jr_q        <= jr_d;
            illegal_q   <= illegal_d;
            md_start_q  <= md_start_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ALUControl = alu_ctrl_q;
    assign JRControl  = jr_q;
    assign illegal    = illegal_q;
    assign md_start   = md_start_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb/tb_alu_control_pipe.sv - directed self-checking bench for alu_control_pipe
module tb_alu_control_pipe;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [5:0] Opcode;
    logic [1:0] ALUOp;
    logic [5:0] Function;
    logic       stall_in;
    logic       flush;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] ALUControl;
    logic       JRControl;
    logic       illegal;
    logic       md_start;
    logic       md_busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_control_pipe #(
        .CTRL_W     (4),
        .MD_LATENCY (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .Opcode     (Opcode),
        .ALUOp      (ALUOp),
        .Function   (Function),
        .stall_in   (stall_in),
        .flush      (flush),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .ALUControl (ALUControl),
        .JRControl  (JRControl),
        .illegal    (illegal),
        .md_start   (md_start),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_r(input logic [5:0] fn);
        in_valid = 1'b1;
        ALUOp    = 2'b00;
        Function = fn;
        Opcode   = 6'b000000;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        Opcode   = 6'b0;
        ALUOp    = 2'b0;
        Function = 6'b0;
        stall_in = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_aluctrl", ALUControl, 0);
        check("rst_jr", JRControl, 0);
        check("rst_illegal", illegal, 0);
        check("rst_md_start", md_start, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_in_ready", in_ready, 1);

        // sub, then idle
        drive_r(6'b100010);
        tick();
        check("sub_valid", out_valid, 1);
        check("sub_ctrl", ALUControl, 4'b0001);
        check("sub_md_start", md_start, 0);
        in_valid = 1'b0;
        tick();
        check("idle_valid", out_valid, 0);
        check("idle_hold_ctrl", ALUControl, 4'b0001);

        // slti via opcode
        in_valid = 1'b1;
        ALUOp    = 2'b11;
        Opcode   = 6'b001010;
        tick();
        check("slti_ctrl", ALUControl, 4'b1000);
        check("slti_illegal", illegal, 0);

        Opcode = 6'b001101;
        tick();
        check("ori_ctrl", ALUControl, 4'b0011);

        Opcode = 6'b111111;
        tick();
        check("unk_op_ctrl", ALUControl, 4'b0000);
        check("unk_op_illegal", illegal, 0);

        // jr
        drive_r(6'b001000);
        tick();
        check("jr_ctrl", ALUControl, 4'b0000);
        check("jr_jr", JRControl, 1);
        check("jr_illegal", illegal, 0);

        // illegal funct
        drive_r(6'b111111);
        tick();
        check("ill_ctrl", ALUControl, 4'b0000);
        check("ill_jr", JRControl, 0);
        check("ill_flag", illegal, 1);

        drive_r(6'b000000);
        tick();
        check("sll_ctrl", ALUControl, 4'b0100);
        check("sll_illegal", illegal, 0);

        ALUOp = 2'b01;
        tick();
        check("branch_ctrl", ALUControl, 4'b0001);
        ALUOp = 2'b10;
        tick();
        check("mem_ctrl", ALUControl, 4'b0000);

        // or followed by 3 stall cycles
        drive_r(6'b100101);
        tick();
        check("or_ctrl", ALUControl, 4'b0011);
        stall_in = 1'b1;
        drive_r(6'b100000);
        #1;
        check("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_ctrl", ALUControl, 4'b0011);
            check("stall_ready", in_ready, 0);
        end
        stall_in = 1'b0;
        in_valid = 1'b0;
        tick();
        check("unstall_valid", out_valid, 0);

        // mult, latency 4, with a pending add
        drive_r(6'b011000);
        tick();
        check("mult_valid", out_valid, 1);
        check("mult_ctrl", ALUControl, 4'b1001);
        drive_r(6'b100000);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mult_busy", md_busy, 1);
            check("mult_ready", in_ready, 0);
            check("mult_start", md_start, (i == 0) ? 1 : 0);
            if (i == 3) begin
                check("mult_hold_ctrl", ALUControl, 4'b1001);
                check("mult_valid_clr", out_valid, 0);
            end
            tick();
        end
        check("mult_done_busy", md_busy, 0);
        check("mult_done_ready", in_ready, 1);
        tick();
        check("add_after_valid", out_valid, 1);
        check("add_after_ctrl", ALUControl, 4'b0000);
        check("add_after_start", md_start, 0);
        in_valid = 1'b0;
        tick();

        // div flushed in second busy cycle
        drive_r(6'b011010);
        tick();
        check("div_ctrl", ALUControl, 4'b1011);
        check("div_busy1", md_busy, 1);
        in_valid = 1'b0;
        tick();
        check("div_busy2", md_busy, 1);
        flush = 1'b1;
        #1;
        check("flush_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_valid", out_valid, 0);
        check("flush_busy", md_busy, 0);
        check("flush_start", md_start, 0);
        check("flush_ready_after", in_ready, 1);

        // flush beats an accept
        drive_r(6'b011000);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_acc_valid", out_valid, 0);
        check("flush_acc_busy", md_busy, 0);
        check("flush_acc_start", md_start, 0);

        // reset mid-busy
        drive_r(6'b011011);
        tick();
        check("divu_ctrl", ALUControl, 4'b1100);
        check("divu_busy", md_busy, 1);
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_busy", md_busy, 0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ctrl", ALUControl, 0);
        check("rst_mid_ready", in_ready, 1);

        // full latency again after reset
        drive_r(6'b011001);
        tick();
        in_valid = 1'b0;
        check("multu_ctrl", ALUControl, 4'b1010);
        tick();
        tick();
        tick();
        check("multu_busy_last", md_busy, 1);
        tick();
        check("multu_idle", md_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
